// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and the MEM stage.
// Data accesses win ties unless fetch has been starved for STARVE_LIMIT grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_done_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic [31:0] d_rdata_o,
  output logic        d_done_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);
  localparam logic [3:0] WaitMax   = 4'(MAX_WAIT);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic        bus_err_q, bus_err_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic        busy;
  logic        finish;
  logic [31:0] captured;
  logic [3:0]  wait_inc;

  assign busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign wait_inc = wait_cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    bus_err_d    = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    finish       = 1'b0;
    captured     = 32'd0;

    case (state_q)
      IDLE: begin
        // A starved fetch only overrides the data port when both are asking.
        if (d_req_i && !(if_req_i && (starve_cnt_q == StarveMax))) begin
          state_d    = BUSY_D;
          we_d       = d_we_i;
          addr_d     = d_addr_i;
          wdata_d    = d_wdata_i;
          be_d       = d_be_i;
          wait_cnt_d = 4'd0;
          if (if_req_i) starve_cnt_d = starve_cnt_q + 3'd1;
        end else if (if_req_i) begin
          state_d      = BUSY_I;
          we_d         = 1'b0;
          addr_d       = if_addr_i;
          wdata_d      = 32'd0;
          be_d         = 4'hF;
          wait_cnt_d   = 4'd0;
          starve_cnt_d = 3'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready_i) begin
          finish   = 1'b1;
          captured = we_q ? 32'd0 : mem_rdata_i;
        end else if (wait_inc == WaitMax) begin
          finish    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
        if (finish) begin
          state_d = RESP;
          if (state_q == BUSY_D) begin
            d_done_d  = 1'b1;
            d_rdata_d = captured;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = captured;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      bus_err_q    <= 1'b0;
      wait_cnt_q   <= 4'd0;
      starve_cnt_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      bus_err_q    <= bus_err_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_done_o   = if_done_q;
  assign d_done_o    = d_done_q;
  assign bus_err_o   = bus_err_q;
  assign stall_if_o  = if_req_i & ~if_done_q;
  assign stall_mem_o = d_req_i & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and completions are queued
// as requests are driven and checked when the shared port / done pulses appear.
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } grant_t;

  typedef struct {
    logic        isData;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  logic        clk_i;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_done_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_rdata_o;
  logic        d_done_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        bus_err_o;

  int     vecCount = 0;
  int     missCount = 0;
  int     readyDelay = 0;
  logic   spuriousReady = 1'b0;
  int     busyCnt = 0;
  int     lastBusyLen = 0;
  grant_t expGrant[$];
  done_t  expDone[$];
  grant_t monGrant;
  done_t  monDone;

  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
    .bus_err_o(bus_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic pushFetch(input logic [31:0] addr);
    expGrant.push_back('{1'b0, addr, 32'd0, 4'hF});
    expDone.push_back('{1'b0, memWord(addr), 1'b0});
  endtask

  task automatic pushData(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic err);
    expGrant.push_back('{we, addr, wdata, be});
    expDone.push_back('{1'b1, (we || err) ? 32'd0 : memWord(addr), err});
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic dReq,
                               input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic [3:0] dBe);
    @(posedge clk_i);
    #1;
    if_req_i  = ifReq;
    if_addr_i = ifAddr;
    d_req_i   = dReq;
    d_we_i    = dWe;
    d_addr_i  = dAddr;
    d_wdata_i = dWdata;
    d_be_i    = dBe;
  endtask

  // Waits for the requested number of completions, releasing each request on its done.
  task automatic runUntil(input int wantI, input int wantD, input int budget, output int lat);
    int gotI = 0;
    int gotD = 0;
    int cyc = 0;
    lat = 0;
    while ((gotI < wantI || gotD < wantD) && cyc < budget) begin
      @(negedge clk_i);
      #1;
      cyc++;
      if (if_req_i) checkOutput("stall_if", {31'd0, stall_if_o}, {31'd0, ~if_done_o});
      if (d_req_i) checkOutput("stall_mem", {31'd0, stall_mem_o}, {31'd0, ~d_done_o});
      if (if_done_o) begin gotI++; if_req_i = 1'b0; lat = cyc; end
      if (d_done_o) begin gotD++; d_req_i = 1'b0; lat = cyc; end
    end
    checkOutput("done_count", 32'(gotI + gotD), 32'(wantI + wantD));
  endtask

  // Memory model plus monitor: answers the port and checks grants and completions.
  always @(negedge clk_i) begin
    if (mem_req_o) begin
      if (busyCnt == 0) begin
        if (expGrant.size() == 0) begin
          checkOutput("grant_unexpected", {31'd0, mem_req_o}, 32'd0);
        end else begin
          monGrant = expGrant.pop_front();
          checkOutput("grant_we", {31'd0, mem_we_o}, {31'd0, monGrant.we});
          checkOutput("grant_addr", mem_addr_o, monGrant.addr);
          checkOutput("grant_wdata", mem_wdata_o, monGrant.wdata);
          checkOutput("grant_be", {28'd0, mem_be_o}, {28'd0, monGrant.be});
        end
      end
      mem_ready_i = (readyDelay >= 0) && (busyCnt == readyDelay);
      mem_rdata_i = memWord(mem_addr_o);
      busyCnt++;
      lastBusyLen = busyCnt;
    end else begin
      busyCnt = 0;
      mem_ready_i = spuriousReady;
      mem_rdata_i = 32'hBAD0BAD0;
    end
    if (if_done_o || d_done_o) begin
      if (expDone.size() == 0) begin
        checkOutput("done_unexpected", {30'd0, if_done_o, d_done_o}, 32'd0);
      end else begin
        monDone = expDone.pop_front();
        checkOutput("done_owner", {30'd0, if_done_o, d_done_o}, {30'd0, ~monDone.isData, monDone.isData});
        if (monDone.isData) checkOutput("d_rdata", d_rdata_o, monDone.rdata);
        else checkOutput("if_rdata", if_rdata_o, monDone.rdata);
        checkOutput("bus_err", {31'd0, bus_err_o}, {31'd0, monDone.err});
      end
    end else begin
      checkOutput("bus_err_idle", {31'd0, bus_err_o}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int lat;
    int dN;
    int iN;
    int cyc;
    rst_ni = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'd0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'd0; d_wdata_i = 32'd0; d_be_i = 4'd0;
    mem_ready_i = 1'b0; mem_rdata_i = 32'd0;
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst_done", {30'd0, if_done_o, d_done_o}, 32'd0);
    checkOutput("rst_if_rdata", if_rdata_o, 32'd0);
    checkOutput("rst_d_rdata", d_rdata_o, 32'd0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
    checkOutput("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    rst_ni = 1'b1;

    readyDelay = 2;
    pushFetch(32'h100);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    runUntil(1, 0, 40, lat);
    checkOutput("fetch_latency", 32'(lat), 32'd5);

    readyDelay = 0;
    pushData(1'b0, 32'h180, 32'd0, 4'hF, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h180, 32'd0, 4'hF);
    runUntil(0, 1, 20, lat);
    checkOutput("min_latency", 32'(lat), 32'd3);

    readyDelay = 1;
    pushData(1'b1, 32'h200, 32'h12345678, 4'b0011, 1'b0);
    pushFetch(32'h300);
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
    runUntil(1, 1, 40, lat);

    readyDelay = 0;
    for (int k = 0; k < 4; k++) pushData(1'b0, 32'h400 + 32'(4 * k), 32'd0, 4'hF, 1'b0);
    pushFetch(32'h500);
    pushData(1'b0, 32'h410, 32'd0, 4'hF, 1'b0);
    pushFetch(32'h504);
    applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h400, 32'd0, 4'hF);
    dN = 0; iN = 0; cyc = 0;
    while ((dN < 5 || iN < 2) && cyc < 100) begin
      @(negedge clk_i);
      #1;
      cyc++;
      if (d_done_o) begin
        dN++;
        if (dN < 5) d_addr_i = 32'h400 + 32'(4 * dN);
        else d_req_i = 1'b0;
      end
      if (if_done_o) begin
        iN++;
        if (iN == 1) if_addr_i = 32'h504;
        else if_req_i = 1'b0;
      end
    end
    checkOutput("starve_data_done", 32'(dN), 32'd5);
    checkOutput("starve_fetch_done", 32'(iN), 32'd2);

    readyDelay = -1;
    pushData(1'b0, 32'h600, 32'hCAFE0000, 4'hF, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h600, 32'hCAFE0000, 4'hF);
    runUntil(0, 1, 40, lat);
    checkOutput("timeout_latency", 32'(lat), 32'd17);
    checkOutput("timeout_busy_len", 32'(lastBusyLen), 32'd15);
    checkOutput("timeout_mem_req", {31'd0, mem_req_o}, 32'd0);

    expGrant.push_back('{1'b0, 32'h700, 32'd0, 4'hF});
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h700, 32'd0, 4'hF);
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("midrst_mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("midrst_if_rdata", if_rdata_o, 32'd0);
    checkOutput("midrst_mem_addr", mem_addr_o, 32'd0);
    d_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    readyDelay = 1;
    pushData(1'b0, 32'h704, 32'd0, 4'hF, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h704, 32'd0, 4'hF);
    runUntil(0, 1, 20, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd4);

    spuriousReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      #1;
      checkOutput("spur_mem_req", {31'd0, mem_req_o}, 32'd0);
      checkOutput("spur_done", {30'd0, if_done_o, d_done_o}, 32'd0);
    end
    spuriousReady = 1'b0;
    readyDelay = 0;
    pushFetch(32'h800);
    applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    runUntil(1, 0, 20, lat);
    checkOutput("spur_after_latency", 32'(lat), 32'd3);

    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("grant_queue_left", 32'(expGrant.size()), 32'd0);
    checkOutput("done_queue_left", 32'(expDone.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
